// File: rtl/rle_decode.sv
// rle_decode: expands a (count, byte) run-length frame from port-A SRAM and writes the plaintext back into the same SRAM.
module rle_decode #(
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       rle_addr,
   input  logic [31:0]       rle_size,
   input  logic [31:0]       message_addr,
   output logic [CNT_W-1:0]  message_size,
   output logic              done,
   output logic              port_A_clk,
   output logic [ADDR_W-1:0] port_A_addr,
   output logic              port_A_we,
   output logic [31:0]       port_A_data_in,
   input  logic [31:0]       port_A_data_out
);
   typedef enum logic [2:0] {IDLE, RD_REQ, RD_CAP, EXPAND, WRITE, FLUSH, FIN} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
   logic [31:0]       rem_q, rem_d, word_q, word_d, pack_q, pack_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              idx_q, idx_d, two_q, two_d, exh_q, exh_d, done_q, done_d;
   logic [CNT_W-1:0]  msize_q, msize_d;
   logic [1:0]        lane;
   logic [7:0]        cur_byte;
   logic              last_pair, adv;
   state_t            after;
   logic              unused_bits;
   assign unused_bits = ^{rle_addr[31:ADDR_W], message_addr[31:ADDR_W]};
   assign lane      = msize_q[1:0];
   assign cur_byte  = idx_q ? word_q[31:24] : word_q[15:8];
   assign last_pair = idx_q || !two_q;
   assign adv       = cnt_q <= 8'd1;
   assign after     = (rem_q != 32'd0) ? RD_REQ : FLUSH;
   always_comb begin
      state_d = state_q;
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      rem_d   = rem_q;
      word_d  = word_q;
      pack_d  = pack_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      two_d   = two_q;
      exh_d   = exh_q;
      msize_d = msize_q;
      done_d  = done_q;
      case (state_q)
         IDLE: if (start) begin
            rptr_d  = rle_addr[ADDR_W-1:0];
            wptr_d  = message_addr[ADDR_W-1:0];
            rem_d   = rle_size;
            msize_d = '0;
            done_d  = 1'b0;
            pack_d  = '0;
            state_d = (rle_size == 32'd0) ? FIN : RD_REQ;
         end
         RD_REQ: state_d = RD_CAP;
         RD_CAP: begin
            word_d  = port_A_data_out;
            cnt_d   = port_A_data_out[7:0];
            idx_d   = 1'b0;
            two_d   = rem_q >= 32'd4;
            rem_d   = (rem_q >= 32'd4) ? rem_q - 32'd4 : 32'd0;
            rptr_d  = rptr_q + ADDR_W'(4);
            state_d = EXPAND;
         end
         EXPAND: begin
            if (cnt_q != 8'd0) begin
               pack_d  = pack_q | ({24'd0, cur_byte} << {lane, 3'b000});
               msize_d = msize_q + CNT_W'(1);
               cnt_d   = cnt_q - 8'd1;
            end
            if (adv && !last_pair) begin
               idx_d = 1'b1;
               cnt_d = word_q[23:16];
            end
            exh_d   = adv && last_pair;
            state_d = (cnt_q != 8'd0 && lane == 2'd3) ? WRITE : (adv && last_pair) ? after : EXPAND;
         end
         WRITE: begin
            wptr_d  = wptr_q + ADDR_W'(4);
            pack_d  = '0;
            state_d = exh_q ? after : EXPAND;
         end
         FLUSH: state_d = FIN;
         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rptr_q  <= '0;
         wptr_q  <= '0;
         rem_q   <= '0;
         word_q  <= '0;
         pack_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= 1'b0;
         two_q   <= 1'b0;
         exh_q   <= 1'b0;
         msize_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         rem_q   <= rem_d;
         word_q  <= word_d;
         pack_q  <= pack_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         two_q   <= two_d;
         exh_q   <= exh_d;
         msize_q <= msize_d;
         done_q  <= done_d;
      end
   end
   // Writes are decoded from state so an async reset drops we in the same cycle.
   assign port_A_we      = (state_q == WRITE) || (state_q == FLUSH && lane != 2'd0);
   assign port_A_addr    = port_A_we ? wptr_q : rptr_q;
   assign port_A_data_in = pack_q;
   assign port_A_clk     = clk;
   assign message_size   = msize_q;
   assign done           = done_q;
endmodule

// File: tb/tb_rle_decode.sv
// tb_rle_decode: vector table, hand sequences and random frames checked against a byte-queue model of RLE expansion.
module tb_rle_decode;
   logic        clk = 1'b0;
   logic        reset, start, done, port_A_clk, port_A_we;
   logic [31:0] rle_addr, rle_size, message_addr, message_size, port_A_data_in, port_A_data_out;
   logic [15:0] port_A_addr;
   int          checks = 0, errors = 0;
   logic [31:0] mem [0:16383];
   logic [31:0] wa[$], wd[$], wq[$];
   int          last_cyc, last_nw;
   logic [31:0] last_data;
   typedef struct {
      logic [31:0] sz, w0, w1, msize;
      int          nw;
      logic [31:0] last;
   } vec_t;
   vec_t vt [7];
   rle_decode dut (
      .clk(clk), .reset(reset), .start(start), .rle_addr(rle_addr), .rle_size(rle_size),
      .message_addr(message_addr), .message_size(message_size), .done(done),
      .port_A_clk(port_A_clk), .port_A_addr(port_A_addr), .port_A_we(port_A_we),
      .port_A_data_in(port_A_data_in), .port_A_data_out(port_A_data_out)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      port_A_data_out <= mem[port_A_addr[15:2]];
      if (port_A_we) begin
         mem[port_A_addr[15:2]] <= port_A_data_in;
         wa.push_back({16'd0, port_A_addr});
         wd.push_back(port_A_data_in);
      end
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask
   task automatic run(input logic [31:0] ra, input logic [31:0] ma, input logic [31:0] sz, input int bound);
      logic [7:0]  eb[$];
      logic [31:0] ea[$], ed[$];
      logic [31:0] w, d;
      logic [7:0]  c, b;
      int          cyc, n;
      for (int i = 0; i < wq.size(); i++) mem[14'(int'(ra[15:2]) + i)] = wq[i];
      for (int p = 0; p < int'(sz / 2); p++) begin
         w = wq[p / 2];
         c = (p % 2 == 1) ? w[23:16] : w[7:0];
         b = (p % 2 == 1) ? w[31:24] : w[15:8];
         for (int k = 0; k < int'(c); k++) eb.push_back(b);
      end
      for (int k = 0; k < eb.size(); k += 4) begin
         d = 32'd0;
         for (int j = 0; j < 4; j++) if (k + j < eb.size()) d[8*j +: 8] = eb[k + j];
         ea.push_back({16'd0, 16'(ma + 32'(k))});
         ed.push_back(d);
      end
      @(negedge clk);
      wa.delete();
      wd.delete();
      rle_addr = ra;
      message_addr = ma;
      rle_size = sz;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < bound) begin
         @(negedge clk);
         cyc++;
      end
      chk("done", {31'd0, done}, 32'd1);
      chk("msize", message_size, 32'(eb.size()));
      chk("nwrites", 32'(wa.size()), 32'(ea.size()));
      n = (wa.size() < ea.size()) ? wa.size() : ea.size();
      for (int k = 0; k < n; k++) begin
         chk("waddr", wa[k], ea[k]);
         chk("wdata", wd[k], ed[k]);
      end
      last_cyc = cyc;
      last_nw = wa.size();
      last_data = (wa.size() > 0) ? wd[wa.size() - 1] : 32'd0;
   endtask
   initial begin
      int n;
      vt[0] = '{32'd4, 32'h42024103, 32'h0,        32'd5,   2,  32'h00000042};
      vt[1] = '{32'd0, 32'h42024103, 32'h0,        32'd0,   0,  32'h0};
      vt[2] = '{32'd2, 32'hFFFF4103, 32'h0,        32'd3,   1,  32'h00414141};
      vt[3] = '{32'd4, 32'h4300FF05, 32'h0,        32'd5,   2,  32'h000000FF};
      vt[4] = '{32'd4, 32'h00005AFF, 32'h0,        32'd255, 64, 32'h005A5A5A};
      vt[5] = '{32'd8, 32'h42024103, 32'h43044401, 32'd10,  3,  32'h00004343};
      vt[6] = '{32'd6, 32'h00000000, 32'h00000107, 32'd7,   2,  32'h00010101};
      reset = 1'b1;
      start = 1'b0;
      rle_addr = 32'd0;
      rle_size = 32'd0;
      message_addr = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_msize", message_size, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_we", {31'd0, port_A_we}, 32'd0);
      chk("rst_addr", {16'd0, port_A_addr}, 32'd0);
      chk("rst_wdata", port_A_data_in, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 7; i++) begin
         wq.delete();
         wq.push_back(vt[i].w0);
         wq.push_back(vt[i].w1);
         run(32'h4000 + 32'(i * 16), 32'h8000 + 32'(i * 1024), vt[i].sz, 2000);
         chk("tbl_msize", message_size, vt[i].msize);
         chk("tbl_nw", 32'(last_nw), 32'(vt[i].nw));
         if (vt[i].nw > 0) chk("tbl_last", last_data, vt[i].last);
         if (vt[i].sz == 32'd0) chk("zero_lat", {31'd0, last_cyc <= 3}, 32'd1);
         repeat (4) @(negedge clk);
         chk("hold_done", {31'd0, done}, 32'd1);
         chk("hold_msize", message_size, vt[i].msize);
      end
      // Interrupt a long run exactly while a word write is on the port.
      mem[14'h1400] = 32'h00005AFF;
      @(negedge clk);
      rle_addr = 32'h5000;
      message_addr = 32'h9000;
      rle_size = 32'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!port_A_we && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("mid_we_seen", {31'd0, port_A_we}, 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_we", {31'd0, port_A_we}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_msize", message_size, 32'd0);
      n = wa.size();
      repeat (3) @(negedge clk);
      chk("mid_rst_nowr", 32'(wa.size()), 32'(n));
      reset = 1'b0;
      wq.delete();
      wq.push_back(32'h42024103);
      run(32'h4100, 32'hA000, 32'd4, 2000);
      chk("post_rst_last", last_data, 32'h00000042);
      for (int i = 0; i < 20; i++) begin
         wq.delete();
         for (int k = 0; k < 4; k++) wq.push_back($urandom & 32'hFF1FFF1F);
         run(32'h4000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00},
             (i % 4 == 0) ? 32'hABCDFFF0 : 32'h00018000 + {20'd0, 8'($urandom_range(0, 255)), 4'h0},
             32'(2 * $urandom_range(0, 8)), 5000);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
